survival_wave_ctrl: RTL

SURVIVAL_WAVE_CTRL -- requirements
Module: survival_wave_ctrl

---
 rtl/survival_wave_if.sv | 27 ++
 rtl/survival_wave_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/survival_wave_if.sv
// Bundle of game-control signals between the frame/key front end and
// survival_wave_ctrl.
interface survival_wave_if;
    logic       startOfFrame;
    logic       startN;
    logic       gameOver;
    logic [7:0] ballActive;
    logic       startGame;
    logic       SMBallDR;
    logic       spawnReq;
    logic [2:0] spawnIdx;
    logic [3:0] level;
    logic [6:0] secLeft;
    logic       tc;

    modport master (
        output startOfFrame, startN, gameOver, ballActive,
        input  startGame, SMBallDR, spawnReq, spawnIdx,
        input  level, secLeft, tc
    );

    modport slave (
        input  startOfFrame, startN, gameOver, ballActive,
        output startGame, SMBallDR, spawnReq, spawnIdx,
        output level, secLeft, tc
    );
endinterface

// File: rtl/survival_wave_ctrl.sv
// Survival-round controller: round timer, difficulty ramp and ball
// spawn scheduling for a frame-paced arcade game.
module survival_wave_ctrl #(
    parameter int FRAMES_PER_SEC = 60,
    parameter int ROUND_SEC      = 60,
    parameter int LEVEL_SEC      = 15,
    parameter int SPAWN_BASE     = 120,
    parameter int SPAWN_STEP     = 15,
    parameter int SPAWN_MIN      = 30
) (
    input  logic           clk,
    input  logic           reset,
    survival_wave_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PLAY, WIN, LOSE} state_t;

    localparam logic [11:0] FPS_M1 = 12'(FRAMES_PER_SEC - 1);
    localparam logic [6:0]  ROUND7 = 7'(ROUND_SEC);
    localparam logic [6:0]  LVL_M1 = 7'(LEVEL_SEC - 1);
    localparam logic [11:0] BASE12 = 12'(SPAWN_BASE);
    localparam logic [11:0] STEP12 = 12'(SPAWN_STEP);
    localparam logic [11:0] MIN12  = 12'(SPAWN_MIN);

    state_t      state_q, state_d;
    logic [11:0] frame_cnt_q, frame_cnt_d;
    logic [11:0] intv_cnt_q, intv_cnt_d;
    logic [6:0]  lvl_sec_q, lvl_sec_d;
    logic [6:0]  sec_left_q, sec_left_d;
    logic [3:0]  level_q, level_d;
    logic        pending_q, pending_d;
    logic        start_game_q, start_game_d;
    logic        draw_q, draw_d;
    logic        spawn_req_q, spawn_req_d;
    logic [2:0]  spawn_idx_q, spawn_idx_d;
    logic        tc_q, tc_d;

    logic [11:0] step_prod;
    logic [11:0] reload;
    logic [2:0]  free_idx;
    logic        free_any;
    logic        expire;
    logic        spawn;

    // Interval shrinks with level but clamps at the floor without wrapping.
    always_comb begin
        step_prod = 12'(level_q) * STEP12;
        if (step_prod >= BASE12 || (BASE12 - step_prod) < MIN12)
            reload = MIN12;
        else
            reload = BASE12 - step_prod;
    end

    always_comb begin
        free_any = 1'b0;
        free_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (!bus.ballActive[i]) begin
                free_any = 1'b1;
                free_idx = 3'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        intv_cnt_d   = intv_cnt_q;
        lvl_sec_d    = lvl_sec_q;
        sec_left_d   = sec_left_q;
        level_d      = level_q;
        pending_d    = pending_q;
        start_game_d = 1'b0;
        spawn_req_d  = 1'b0;
        spawn_idx_d  = 3'd0;
        tc_d         = 1'b0;
        expire       = 1'b0;
        spawn        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!bus.startN) begin
                    state_d      = PLAY;
                    start_game_d = 1'b1;
                    frame_cnt_d  = 12'd0;
                    sec_left_d   = ROUND7;
                    level_d      = 4'd0;
                    lvl_sec_d    = 7'd0;
                    intv_cnt_d   = BASE12;
                    pending_d    = 1'b0;
                end
            end
            PLAY: begin
                if (bus.startOfFrame) begin
                    if (frame_cnt_q == FPS_M1) begin
                        frame_cnt_d = 12'd0;
                        if (sec_left_q != 7'd0) begin
                            sec_left_d = sec_left_q - 7'd1;
                            if (sec_left_q == 7'd1) begin
                                tc_d    = 1'b1;
                                state_d = WIN;
                            end
                            if (lvl_sec_q == LVL_M1) begin
                                lvl_sec_d = 7'd0;
                                if (level_q != 4'hF)
                                    level_d = level_q + 4'd1;
                            end else begin
                                lvl_sec_d = lvl_sec_q + 7'd1;
                            end
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 12'd1;
                    end
                    // Counter never rests at 0: the frame that would reach 0 reloads.
                    if (intv_cnt_q <= 12'd1) begin
                        intv_cnt_d = reload;
                        expire     = 1'b1;
                    end else begin
                        intv_cnt_d = intv_cnt_q - 12'd1;
                    end
                end
                if (bus.gameOver)
                    state_d = LOSE;
                spawn = (state_d == PLAY) && pending_q && free_any && !spawn_req_q;
                if (spawn) begin
                    spawn_req_d = 1'b1;
                    spawn_idx_d = free_idx;
                end
                pending_d = (pending_q && !spawn) || expire;
            end
            default: begin
            end
        endcase
        draw_d = (state_d == PLAY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            frame_cnt_q  <= 12'd0;
            intv_cnt_q   <= BASE12;
            lvl_sec_q    <= 7'd0;
            sec_left_q   <= ROUND7;
            level_q      <= 4'd0;
            pending_q    <= 1'b0;
            start_game_q <= 1'b0;
            draw_q       <= 1'b0;
            spawn_req_q  <= 1'b0;
            spawn_idx_q  <= 3'd0;
            tc_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            intv_cnt_q   <= intv_cnt_d;
            lvl_sec_q    <= lvl_sec_d;
            sec_left_q   <= sec_left_d;
            level_q      <= level_d;
            pending_q    <= pending_d;
            start_game_q <= start_game_d;
            draw_q       <= draw_d;
            spawn_req_q  <= spawn_req_d;
            spawn_idx_q  <= spawn_idx_d;
            tc_q         <= tc_d;
        end
    end

    assign bus.startGame = start_game_q;
    assign bus.SMBallDR  = draw_q;
    assign bus.spawnReq  = spawn_req_q;
    assign bus.spawnIdx  = spawn_idx_q;
    assign bus.level     = level_q;
    assign bus.secLeft   = sec_left_q;
    assign bus.tc        = tc_q;
endmodule
